cpu_mem_axi_responder: RTL and testbench

//  AXI4 responder (memory model) for the CPU data port: accepts AR/AW/W bursts from a cache

---
 rtl/cpu_mem_axi_responder_if.sv | 46 ++++
 rtl/cpu_mem_axi_responder.sv | 132 +++++++++++++
 tb/tb_cpu_mem_axi_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_axi_responder_if.sv
// cpu_mem_axi_responder_if: AXI4 CPU data-port bus between a cache master and the memory responder
// Groups AR, AW, W, R and B channels. The master drives addresses, write data and the R/B readies.
// The slave drives the AR/AW/W readies, read data and both response valids.
interface cpu_mem_axi_responder_if;
    logic [39:0] cpu_mem_araddr;
    logic        cpu_mem_arvalid;
    logic        cpu_mem_arready;
    logic [7:0]  cpu_mem_arlen;
    logic [2:0]  cpu_mem_arsize;
    logic [1:0]  cpu_mem_arburst;
    logic [39:0] cpu_mem_awaddr;
    logic        cpu_mem_awvalid;
    logic        cpu_mem_awready;
    logic [7:0]  cpu_mem_awlen;
    logic [2:0]  cpu_mem_awsize;
    logic [1:0]  cpu_mem_awburst;
    logic [31:0] cpu_mem_rdata;
    logic        cpu_mem_rvalid;
    logic        cpu_mem_rready;
    logic        cpu_mem_rlast;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_wvalid;
    logic        cpu_mem_wready;
    logic        cpu_mem_wlast;
    logic        cpu_mem_bvalid;
    logic        cpu_mem_bready;

    modport master (
        output cpu_mem_araddr, cpu_mem_arvalid, cpu_mem_arlen, cpu_mem_arsize, cpu_mem_arburst,
        output cpu_mem_awaddr, cpu_mem_awvalid, cpu_mem_awlen, cpu_mem_awsize, cpu_mem_awburst,
        output cpu_mem_rready, cpu_mem_wdata, cpu_mem_wstrb, cpu_mem_wvalid, cpu_mem_wlast,
        output cpu_mem_bready,
        input  cpu_mem_arready, cpu_mem_awready, cpu_mem_rdata, cpu_mem_rvalid, cpu_mem_rlast,
        input  cpu_mem_wready, cpu_mem_bvalid
    );

    modport slave (
        input  cpu_mem_araddr, cpu_mem_arvalid, cpu_mem_arlen, cpu_mem_arsize, cpu_mem_arburst,
        input  cpu_mem_awaddr, cpu_mem_awvalid, cpu_mem_awlen, cpu_mem_awsize, cpu_mem_awburst,
        input  cpu_mem_rready, cpu_mem_wdata, cpu_mem_wstrb, cpu_mem_wvalid, cpu_mem_wlast,
        input  cpu_mem_bready,
        output cpu_mem_arready, cpu_mem_awready, cpu_mem_rdata, cpu_mem_rvalid, cpu_mem_rlast,
        output cpu_mem_wready, cpu_mem_bvalid
    );
endinterface

// File: rtl/cpu_mem_axi_responder.sv
// cpu_mem_axi_responder: AXI4 memory model serving 32-bit INCR bursts for the CPU data port
// Ports: cpu_clk/cpu_reset (sync, active high); bus (slave side of cpu_mem_axi_responder_if);
//        proto_err (sticky flag, wlast disagreed with awlen, cleared only by reset).
// Reads and writes share one FSM; simultaneous AR/AW requests alternate via grant_wr.
module cpu_mem_axi_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int RD_LAT    = 2
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_reset,
    cpu_mem_axi_responder_if.slave bus,
    output logic                   proto_err
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_END = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t        state, state_nx;
    logic [31:0]   mem [MEM_WORDS];
    logic [IW-1:0] idx, rd_idx;
    logic [7:0]    len, cnt;
    logic [3:0]    lat;
    logic          grant_wr, rd_load, last;
    logic          ar_hs, aw_hs, r_hs, w_hs;
    logic          unused;

    assign unused = ^{bus.cpu_mem_araddr[39:IW+2], bus.cpu_mem_awaddr[39:IW+2],
                      bus.cpu_mem_arsize, bus.cpu_mem_arburst, bus.cpu_mem_awsize, bus.cpu_mem_awburst,
                      bus.cpu_mem_araddr[1:0], bus.cpu_mem_awaddr[1:0]};

    assign last  = cnt == len;
    assign ar_hs = bus.cpu_mem_arvalid & bus.cpu_mem_arready;
    assign aw_hs = bus.cpu_mem_awvalid & bus.cpu_mem_awready;
    assign r_hs  = bus.cpu_mem_rvalid & bus.cpu_mem_rready;
    assign w_hs  = bus.cpu_mem_wvalid & bus.cpu_mem_wready;

    // rd_idx/rd_load steer the registered array read so the next beat's data is
    // already in rdata the cycle rvalid (re)asserts.
    always_comb begin
        state_nx            = state;
        bus.cpu_mem_arready = 1'b0;
        bus.cpu_mem_awready = 1'b0;
        bus.cpu_mem_wready  = 1'b0;
        bus.cpu_mem_rvalid  = 1'b0;
        bus.cpu_mem_bvalid  = 1'b0;
        bus.cpu_mem_rlast   = 1'b0;
        rd_load             = 1'b0;
        rd_idx              = idx;
        if (!cpu_reset) begin
            case (state)
                IDLE: begin
                    bus.cpu_mem_arready = bus.cpu_mem_arvalid ? (~bus.cpu_mem_awvalid | ~grant_wr) : 1'b1;
                    bus.cpu_mem_awready = bus.cpu_mem_awvalid ? (~bus.cpu_mem_arvalid | grant_wr) : 1'b1;
                    if (bus.cpu_mem_arvalid && bus.cpu_mem_arready) begin
                        state_nx = (RD_LAT == 0) ? RD_DATA : RD_WAIT;
                        rd_idx   = bus.cpu_mem_araddr[IW+1:2];
                        rd_load  = RD_LAT == 0;
                    end else if (bus.cpu_mem_awvalid && bus.cpu_mem_awready) begin
                        state_nx = WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (lat == LAT_END) begin
                        state_nx = RD_DATA;
                        rd_load  = 1'b1;
                    end
                end
                RD_DATA: begin
                    bus.cpu_mem_rvalid = 1'b1;
                    bus.cpu_mem_rlast  = last;
                    if (bus.cpu_mem_rready) begin
                        state_nx = last ? IDLE : RD_DATA;
                        rd_idx   = idx + 1'b1;
                        rd_load  = ~last;
                    end
                end
                WR_DATA: begin
                    bus.cpu_mem_wready = 1'b1;
                    if (bus.cpu_mem_wvalid && last) state_nx = WR_RESP;
                end
                WR_RESP: begin
                    bus.cpu_mem_bvalid = 1'b1;
                    if (bus.cpu_mem_bready) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state             <= IDLE;
            idx               <= '0;
            len               <= '0;
            cnt               <= '0;
            lat               <= '0;
            grant_wr          <= 1'b1;
            proto_err         <= 1'b0;
            bus.cpu_mem_rdata <= '0;
        end else begin
            state <= state_nx;
            if (rd_load) bus.cpu_mem_rdata <= mem[rd_idx];
            if (ar_hs) begin
                idx      <= bus.cpu_mem_araddr[IW+1:2];
                len      <= bus.cpu_mem_arlen;
                cnt      <= '0;
                lat      <= '0;
                grant_wr <= 1'b1;
            end else if (aw_hs) begin
                idx      <= bus.cpu_mem_awaddr[IW+1:2];
                len      <= bus.cpu_mem_awlen;
                cnt      <= '0;
                grant_wr <= 1'b0;
            end
            if (state == RD_WAIT) lat <= lat + 1'b1;
            if (r_hs || w_hs) begin
                idx <= idx + 1'b1;
                cnt <= cnt + 1'b1;
            end
            if (w_hs && (bus.cpu_mem_wlast != last)) proto_err <= 1'b1;
        end
    end

    // Array has no reset so contents survive cpu_reset; wready is already
    // forced low during reset, so no write can slip in then.
    always_ff @(posedge cpu_clk) begin
        if (w_hs)
            for (int i = 0; i < 4; i++)
                if (bus.cpu_mem_wstrb[i]) mem[idx][8*i +: 8] <= bus.cpu_mem_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_cpu_mem_axi_responder.sv
// tb_cpu_mem_axi_responder: scoreboard bench for the AXI memory responder
module tb_cpu_mem_axi_responder;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic proto_err;
    always #5 clk = ~clk;

    cpu_mem_axi_responder_if bus();

    cpu_mem_axi_responder #(.MEM_WORDS(4096), .RD_LAT(RD_LAT)) dut (
        .cpu_clk(clk),
        .cpu_reset(rst),
        .bus(bus),
        .proto_err(proto_err)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [32:0] exp_r[$];
    logic        exp_g[$];
    logic        exp_perr = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic [32:0] mon_e;
    logic        mon_g;
    logic [31:0] wd[8];
    logic [3:0]  ws[8];
    logic        done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rd(input logic [39:0] a, input logic [7:0] len, input bit pg);
        int n;
        if (pg) exp_g.push_back(1'b0);
        bus.cpu_mem_araddr  = a;
        bus.cpu_mem_arlen   = len;
        bus.cpu_mem_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cpu_mem_arready && n < 500);
        chk("ar_accept", bus.cpu_mem_arready, 1);
        @(posedge clk); #1;
        bus.cpu_mem_arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cpu_mem_rvalid && n < 64);
        chk("rd_latency", n, 1 + RD_LAT);
        n = 0;
        while (!(bus.cpu_mem_rvalid && bus.cpu_mem_rready && bus.cpu_mem_rlast) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rlast_seen", n < 500, 1);
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [39:0] a, input int nb, input int lb, input bit pg);
        int n;
        if (pg) exp_g.push_back(1'b1);
        bus.cpu_mem_awaddr  = a;
        bus.cpu_mem_awlen   = 8'(nb - 1);
        bus.cpu_mem_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cpu_mem_awready && n < 500);
        chk("aw_accept", bus.cpu_mem_awready, 1);
        @(posedge clk); #1;
        bus.cpu_mem_awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.cpu_mem_wdata  = wd[i];
            bus.cpu_mem_wstrb  = ws[i];
            bus.cpu_mem_wlast  = (i == lb);
            bus.cpu_mem_wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.cpu_mem_wready && n < 64);
            chk("w_accept", bus.cpu_mem_wready, 1);
            @(posedge clk); #1;
        end
        bus.cpu_mem_wvalid = 1'b0;
        bus.cpu_mem_wlast  = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cpu_mem_bvalid && n < 64);
        chk("b_latency", n, 1);
        chk("w_past_len", bus.cpu_mem_wready, 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: grants, R beats, rdata stability under stall, B with proto_err.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cpu_mem_arvalid && bus.cpu_mem_arready) begin
                chk("grant_expected", exp_g.size() != 0, 1);
                if (exp_g.size() != 0) begin mon_g = exp_g.pop_front(); chk("grant_type", 0, mon_g); end
            end
            if (bus.cpu_mem_awvalid && bus.cpu_mem_awready) begin
                chk("grant_expected", exp_g.size() != 0, 1);
                if (exp_g.size() != 0) begin mon_g = exp_g.pop_front(); chk("grant_type", 1, mon_g); end
            end
            if (stall_prev && bus.cpu_mem_rvalid) chk("r_stable", bus.cpu_mem_rdata, stall_data);
            if (bus.cpu_mem_rvalid && bus.cpu_mem_rready) begin
                chk("r_expected", exp_r.size() != 0, 1);
                if (exp_r.size() != 0) begin
                    mon_e = exp_r.pop_front();
                    chk("r_beat", {bus.cpu_mem_rlast, bus.cpu_mem_rdata}, mon_e);
                end
            end
            if (bus.cpu_mem_bvalid && bus.cpu_mem_bready) chk("b_proto_err", proto_err, exp_perr);
        end
        stall_prev = !rst && bus.cpu_mem_rvalid && !bus.cpu_mem_rready;
        stall_data = bus.cpu_mem_rdata;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_mem_araddr = '0; bus.cpu_mem_arvalid = 0; bus.cpu_mem_arlen = '0;
        bus.cpu_mem_arsize = 3'b010; bus.cpu_mem_arburst = 2'b01;
        bus.cpu_mem_awaddr = '0; bus.cpu_mem_awvalid = 0; bus.cpu_mem_awlen = '0;
        bus.cpu_mem_awsize = 3'b010; bus.cpu_mem_awburst = 2'b01;
        bus.cpu_mem_rready = 1; bus.cpu_mem_bready = 1;
        bus.cpu_mem_wdata = '0; bus.cpu_mem_wstrb = '0; bus.cpu_mem_wvalid = 0; bus.cpu_mem_wlast = 0;
        done = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {bus.cpu_mem_arready, bus.cpu_mem_awready, bus.cpu_mem_wready,
                            bus.cpu_mem_rvalid, bus.cpu_mem_bvalid, proto_err}, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("idle_ready", {bus.cpu_mem_arready, bus.cpu_mem_awready, bus.cpu_mem_rdata}, {2'b11, 32'h0});
        @(posedge clk); #1;

        // 1: preload words 0x10..0x13, read burst of 4
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + i; ws[i] = 4'hF; end
        wr(40'h40, 4, 3, 1);
        exp_r.push_back({1'b0, 32'hA000_0000});
        exp_r.push_back({1'b0, 32'hA000_0001});
        exp_r.push_back({1'b0, 32'hA000_0002});
        exp_r.push_back({1'b1, 32'hA000_0003});
        rd(40'h40, 3, 1);

        // 2: strobed write over zeroed word, read back
        wd[0] = 32'h0; ws[0] = 4'hF;
        wr(40'h84, 1, 0, 1);
        wd[0] = 32'h1122_3344; ws[0] = 4'b1111;
        wd[1] = 32'hAABB_CCDD; ws[1] = 4'b0101;
        wr(40'h80, 2, 1, 1);
        exp_r.push_back({1'b0, 32'h1122_3344});
        exp_r.push_back({1'b1, 32'h00BB_00DD});
        rd(40'h80, 1, 1);

        // 4: read of 8 with rready toggling
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hC000_0000 + i; ws[i] = 4'hF; end
        wr(40'h100, 8, 7, 1);
        for (int i = 0; i < 8; i++) exp_r.push_back({i == 7, 32'hC000_0000 + i});
        fork
            begin rd(40'h100, 7, 1); done = 1; end
            begin
                for (int k = 0; k < 300 && !done; k++) begin
                    @(posedge clk); #1 bus.cpu_mem_rready = ~bus.cpu_mem_rready;
                end
            end
        join
        bus.cpu_mem_rready = 1;
        @(posedge clk); #1;

        // 3: concurrent AR/AW streams, grants alternate starting with write
        for (int i = 0; i < 3; i++) begin exp_g.push_back(1'b1); exp_g.push_back(1'b0); end
        exp_r.push_back({1'b0, 32'hA000_0000});
        exp_r.push_back({1'b1, 32'hA000_0001});
        exp_r.push_back({1'b0, 32'hA000_0002});
        exp_r.push_back({1'b1, 32'hA000_0003});
        exp_r.push_back({1'b0, 32'h1122_3344});
        exp_r.push_back({1'b1, 32'h00BB_00DD});
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    wd[0] = 32'hE000_0000 + i; ws[0] = 4'hF;
                    wr(40'h200 + 40'(4 * i), 1, 0, 0);
                end
            end
            begin
                rd(40'h40, 1, 0);
                rd(40'h48, 1, 0);
                rd(40'h80, 1, 0);
            end
        join
        exp_r.push_back({1'b0, 32'hE000_0000});
        exp_r.push_back({1'b0, 32'hE000_0001});
        exp_r.push_back({1'b1, 32'hE000_0002});
        rd(40'h200, 2, 1);

        // 5: early wlast on beat 2 of 3
        exp_perr = 1'b1;
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h5000_0000 + i; ws[i] = 4'hF; end
        wr(40'h300, 3, 1, 1);
        @(negedge clk);
        chk("proto_err_sticky", proto_err, 1);
        @(posedge clk); #1;

        // 6: wrap at end of array, upper address bits ignored
        wd[0] = 32'hD000_0000; wd[1] = 32'hD000_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        wr(40'h3FFC, 2, 1, 1);
        exp_r.push_back({1'b0, 32'hD000_0000});
        exp_r.push_back({1'b1, 32'hD000_0001});
        rd(40'hF0_0000_3FFC, 1, 1);

        // 6: reset in the middle of a read burst
        for (int i = 0; i < 8; i++) exp_r.push_back({i == 7, 32'hC000_0000 + i});
        exp_g.push_back(1'b0);
        bus.cpu_mem_araddr  = 40'h100;
        bus.cpu_mem_arlen   = 8'd7;
        bus.cpu_mem_arvalid = 1'b1;
        @(negedge clk);
        chk("ar_accept_mid", bus.cpu_mem_arready, 1);
        @(posedge clk); #1 bus.cpu_mem_arvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("rst_mid_valids", {bus.cpu_mem_arready, bus.cpu_mem_awready, bus.cpu_mem_wready,
                               bus.cpu_mem_rvalid, bus.cpu_mem_bvalid}, 0);
        @(posedge clk); #1 rst = 0;
        exp_r.delete();
        exp_perr = 1'b0;
        @(negedge clk);
        chk("post_rst", {proto_err, bus.cpu_mem_rvalid, bus.cpu_mem_rdata, bus.cpu_mem_arready},
            {1'b0, 1'b0, 32'h0, 1'b1});
        @(posedge clk); #1;
        exp_r.push_back({1'b0, 32'hD000_0000});
        exp_r.push_back({1'b1, 32'hD000_0001});
        rd(40'h3FFC, 1, 1);

        repeat (3) @(posedge clk);
        chk("r_queue_drained", exp_r.size(), 0);
        chk("g_queue_drained", exp_g.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
